ysyx_25070198_mem_arbiter: RTL and testbench

// - Two-master, one-slave arbiter for the single pmem port; IFU and LSU share it over the reqValid/respValid bus.
// - Sits between ysyx_25070198_ifu/ysyx_25070198_lsu and the pmem DPI access block in top.
// - One outstanding transaction at a time, tracked by a small FSM.
// - Each transaction is guarded by a response-timeout counter.

---
 rtl/ysyx_25070198_mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_25070198_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25070198_mem_arbiter.sv
// ysyx_25070198_mem_arbiter
//   Two-master, one-slave arbiter that lets the IFU and the LSU share the single pmem port.
//   Only one transaction is in flight at a time. Every transaction has a response timeout
//   that returns an error response when it expires.
//
// Parameters
//   ARB_MODE     0 = fixed priority (LSU wins a tie), 1 = round-robin (last granted loses a tie)
//   TIMEOUT_CYC  cycles spent in BUSY before an error response; 0 disables the timeout
//   CNT_W        timeout counter width; TIMEOUT_CYC must be below 2**CNT_W
//
// Ports
//   clk, rst                        clock, asynchronous active-low reset
//   ifu_reqValid/raddr              IFU read request (held until ifu_reqReady)
//   ifu_reqReady                    IFU request accepted this cycle
//   ifu_respValid/rdata/respErr     IFU response pulse, data, timeout error
//   lsu_reqValid/addr/wen/wdata/wmask  LSU request (held until lsu_reqReady)
//   lsu_reqReady                    LSU request accepted this cycle
//   lsu_respValid/rdata/respErr     LSU response pulse, data, timeout error
//   slv_reqValid/addr/wen/wdata/wmask  latched request to pmem, held until slv_respValid
//   slv_respValid/rdata             pmem response pulse and read data
module ysyx_25070198_mem_arbiter #(
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_reqValid,
    input  logic [31:0] ifu_raddr,
    output logic        ifu_reqReady,
    output logic        ifu_respValid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_respErr,

    input  logic        lsu_reqValid,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_reqReady,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_respErr,

    output logic        slv_reqValid,
    output logic [31:0] slv_addr,
    output logic        slv_wen,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wmask,
    input  logic        slv_respValid,
    input  logic [31:0] slv_rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusyIfu = 2'd1,
        StBusyLsu = 2'd2
    } state_e;

    // Counter value in the last allowed BUSY cycle; meaningless when the timeout is disabled.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit               TimeoutEn   = (TIMEOUT_CYC != 0);

    state_e           state_q, state_d;
    logic             last_lsu_q, last_lsu_d;  // 1: last grant went to the LSU
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             wen_q, wen_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;

    logic grant_ifu, grant_lsu;
    logic busy, timeout_hit, done;

    // Grant is gated by rst so that every output reads 0 while reset is asserted.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == StIdle && rst) begin
            if (ifu_reqValid && lsu_reqValid) begin
                if (ARB_MODE == 0 || !last_lsu_q) begin
                    grant_lsu = 1'b1;
                end else begin
                    grant_ifu = 1'b1;
                end
            end else begin
                grant_ifu = ifu_reqValid;
                grant_lsu = lsu_reqValid;
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign timeout_hit = TimeoutEn && busy && (cnt_q == TimeoutLast);
    assign done        = busy && (slv_respValid || timeout_hit);

    always_comb begin
        state_d    = state_q;
        last_lsu_d = last_lsu_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        unique case (state_q)
            StIdle: begin
                if (grant_lsu) begin
                    state_d    = StBusyLsu;
                    last_lsu_d = 1'b1;
                    cnt_d      = '0;
                    addr_d     = lsu_addr;
                    wen_d      = lsu_wen;
                    wdata_d    = lsu_wdata;
                    wmask_d    = lsu_wmask;
                end else if (grant_ifu) begin
                    state_d    = StBusyIfu;
                    last_lsu_d = 1'b0;
                    cnt_d      = '0;
                    addr_d     = ifu_raddr;
                    wen_d      = 1'b0;
                    wdata_d    = '0;
                    wmask_d    = '0;
                end
            end
            StBusyIfu, StBusyLsu: begin
                if (done) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            last_lsu_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_lsu_q <= last_lsu_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
        end
    end

    assign ifu_reqReady = grant_ifu;
    assign lsu_reqReady = grant_lsu;

    assign slv_reqValid = busy;
    assign slv_addr     = addr_q;
    assign slv_wen      = wen_q;
    assign slv_wdata    = wdata_q;
    assign slv_wmask    = wmask_q;

    // A real response in the timeout cycle wins over the error.
    always_comb begin
        ifu_respValid = 1'b0;
        ifu_respErr   = 1'b0;
        ifu_rdata     = '0;
        lsu_respValid = 1'b0;
        lsu_respErr   = 1'b0;
        lsu_rdata     = '0;
        if (state_q == StBusyIfu) begin
            ifu_respValid = slv_respValid || timeout_hit;
            ifu_respErr   = timeout_hit && !slv_respValid;
            ifu_rdata     = slv_respValid ? slv_rdata : '0;
        end else if (state_q == StBusyLsu) begin
            lsu_respValid = slv_respValid || timeout_hit;
            lsu_respErr   = timeout_hit && !slv_respValid;
            lsu_rdata     = slv_respValid ? slv_rdata : '0;
        end
    end

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Directed bench: dut_a runs fixed priority, dut_b round-robin; both share one stimulus and use
// TIMEOUT_CYC=4.
module tb_ysyx_25070198_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_raddr = '0;
    logic        lsu_reqValid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        slv_respValid = 1'b0;
    logic [31:0] slv_rdata = '0;

    logic        a_ifu_reqReady, a_ifu_respValid, a_ifu_respErr;
    logic [31:0] a_ifu_rdata;
    logic        a_lsu_reqReady, a_lsu_respValid, a_lsu_respErr;
    logic [31:0] a_lsu_rdata;
    logic        a_slv_reqValid, a_slv_wen;
    logic [31:0] a_slv_addr, a_slv_wdata;
    logic [3:0]  a_slv_wmask;

    logic        b_ifu_reqReady, b_ifu_respValid, b_ifu_respErr;
    logic [31:0] b_ifu_rdata;
    logic        b_lsu_reqReady, b_lsu_respValid, b_lsu_respErr;
    logic [31:0] b_lsu_rdata;
    logic        b_slv_reqValid, b_slv_wen;
    logic [31:0] b_slv_addr, b_slv_wdata;
    logic [3:0]  b_slv_wmask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_25070198_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .ifu_reqValid(ifu_reqValid), .ifu_raddr(ifu_raddr), .ifu_reqReady(a_ifu_reqReady),
        .ifu_respValid(a_ifu_respValid), .ifu_rdata(a_ifu_rdata), .ifu_respErr(a_ifu_respErr),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_reqReady(a_lsu_reqReady),
        .lsu_respValid(a_lsu_respValid), .lsu_rdata(a_lsu_rdata), .lsu_respErr(a_lsu_respErr),
        .slv_reqValid(a_slv_reqValid), .slv_addr(a_slv_addr), .slv_wen(a_slv_wen),
        .slv_wdata(a_slv_wdata), .slv_wmask(a_slv_wmask),
        .slv_respValid(slv_respValid), .slv_rdata(slv_rdata)
    );

    ysyx_25070198_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .ifu_reqValid(ifu_reqValid), .ifu_raddr(ifu_raddr), .ifu_reqReady(b_ifu_reqReady),
        .ifu_respValid(b_ifu_respValid), .ifu_rdata(b_ifu_rdata), .ifu_respErr(b_ifu_respErr),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_reqReady(b_lsu_reqReady),
        .lsu_respValid(b_lsu_respValid), .lsu_rdata(b_lsu_rdata), .lsu_respErr(b_lsu_respErr),
        .slv_reqValid(b_slv_reqValid), .slv_addr(b_slv_addr), .slv_wen(b_slv_wen),
        .slv_wdata(b_slv_wdata), .slv_wmask(b_slv_wmask),
        .slv_respValid(slv_respValid), .slv_rdata(slv_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks follow #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
        slv_respValid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Expected grants under a held tie: 1 = LSU, 0 = IFU.
    logic exp_a_lsu [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic exp_b_lsu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state: requests pending but reset held -> all outputs 0.
        rst = 1'b0;
        ifu_reqValid = 1'b1;
        lsu_reqValid = 1'b1;
        tick();
        #1;
        check("rst_ifu_ready", {31'd0, a_ifu_reqReady}, 32'd0);
        check("rst_lsu_ready", {31'd0, b_lsu_reqReady}, 32'd0);
        check("rst_slv_valid", {31'd0, a_slv_reqValid}, 32'd0);
        check("rst_slv_addr", a_slv_addr, 32'd0);
        do_reset();

        // Lone IFU read.
        tick();
        ifu_reqValid = 1'b1;
        ifu_raddr = 32'h8000_0000;
        #1;
        check("ifu_ready_t", {31'd0, a_ifu_reqReady}, 32'd1);
        check("ifu_lsu_ready_t", {31'd0, a_lsu_reqReady}, 32'd0);
        check("ifu_slv_valid_t", {31'd0, a_slv_reqValid}, 32'd0);
        tick();
        ifu_reqValid = 1'b0;
        #1;
        check("ifu_slv_valid_t1", {31'd0, a_slv_reqValid}, 32'd1);
        check("ifu_slv_addr", a_slv_addr, 32'h8000_0000);
        check("ifu_slv_wen", {31'd0, a_slv_wen}, 32'd0);
        tick();
        #1;
        check("ifu_resp_t2", {31'd0, a_ifu_respValid}, 32'd0);
        tick();
        slv_respValid = 1'b1;
        slv_rdata = 32'h0010_0073;
        #1;
        check("ifu_resp_t3", {31'd0, a_ifu_respValid}, 32'd1);
        check("ifu_rdata_t3", a_ifu_rdata, 32'h0010_0073);
        check("ifu_err_t3", {31'd0, a_ifu_respErr}, 32'd0);
        check("ifu_lsu_resp_t3", {31'd0, a_lsu_respValid}, 32'd0);
        check("ifu_lsu_rdata_t3", a_lsu_rdata, 32'd0);
        tick();
        slv_respValid = 1'b0;
        #1;
        check("ifu_idle_t4", {31'd0, a_slv_reqValid}, 32'd0);
        check("ifu_resp_t4", {31'd0, a_ifu_respValid}, 32'd0);

        // Held tie for 4 transactions, fixed priority (dut_a) vs round-robin (dut_b).
        do_reset();
        tick();
        ifu_reqValid = 1'b1;
        ifu_raddr = 32'h8000_0040;
        lsu_reqValid = 1'b1;
        lsu_addr = 32'h8000_0200;
        lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("tie_a_lsu%0d", i), {31'd0, a_lsu_reqReady}, {31'd0, exp_a_lsu[i]});
            check($sformatf("tie_a_ifu%0d", i), {31'd0, a_ifu_reqReady}, {31'd0, !exp_a_lsu[i]});
            check($sformatf("tie_b_lsu%0d", i), {31'd0, b_lsu_reqReady}, {31'd0, exp_b_lsu[i]});
            check($sformatf("tie_b_ifu%0d", i), {31'd0, b_ifu_reqReady}, {31'd0, !exp_b_lsu[i]});
            tick();
            slv_respValid = 1'b1;
            slv_rdata = 32'h1000 + i;
            #1;
            check($sformatf("tie_b_ready_busy%0d", i),
                  {30'd0, b_ifu_reqReady, b_lsu_reqReady}, 32'd0);
            check($sformatf("tie_b_lresp%0d", i), {31'd0, b_lsu_respValid},
                  {31'd0, exp_b_lsu[i]});
            check($sformatf("tie_b_iresp%0d", i), {31'd0, b_ifu_respValid},
                  {31'd0, !exp_b_lsu[i]});
            tick();
            slv_respValid = 1'b0;
        end
        idle_inputs();

        // LSU write; request fields change after acceptance, latched copy must not.
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr = 32'h8000_0100;
        lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'b0001;
        #1;
        check("wr_ready", {31'd0, a_lsu_reqReady}, 32'd1);
        tick();
        lsu_reqValid = 1'b0;
        lsu_addr = 32'h0;
        lsu_wen = 1'b0;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'hf;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("wr_addr%0d", i), a_slv_addr, 32'h8000_0100);
            check($sformatf("wr_wen%0d", i), {31'd0, a_slv_wen}, 32'd1);
            check($sformatf("wr_wdata%0d", i), a_slv_wdata, 32'hDEAD_BEEF);
            check($sformatf("wr_wmask%0d", i), {28'd0, a_slv_wmask}, 32'd1);
            check($sformatf("wr_resp%0d", i), {31'd0, a_lsu_respValid}, 32'd0);
            tick();
        end
        slv_respValid = 1'b1;
        slv_rdata = 32'h1234_5678;
        #1;
        check("wr_resp", {31'd0, a_lsu_respValid}, 32'd1);
        check("wr_rdata", a_lsu_rdata, 32'h1234_5678);
        check("wr_ifu_resp", {31'd0, a_ifu_respValid}, 32'd0);
        tick();
        slv_respValid = 1'b0;
        #1;
        check("wr_resp_after", {31'd0, a_lsu_respValid}, 32'd0);
        check("wr_idle", {31'd0, a_slv_reqValid}, 32'd0);

        // Timeout: slave silent, error in the 4th BUSY cycle.
        tick();
        ifu_reqValid = 1'b1;
        ifu_raddr = 32'h8000_0300;
        slv_rdata = 32'hCAFE_F00D;
        #1;
        check("to_ready", {31'd0, a_ifu_reqReady}, 32'd1);
        tick();
        ifu_reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("to_wait%0d", i), {31'd0, a_ifu_respValid}, 32'd0);
            tick();
        end
        #1;
        check("to_resp", {31'd0, a_ifu_respValid}, 32'd1);
        check("to_err", {31'd0, a_ifu_respErr}, 32'd1);
        check("to_rdata", a_ifu_rdata, 32'd0);
        tick();
        slv_respValid = 1'b1;
        #1;
        check("to_late_ifu", {31'd0, a_ifu_respValid}, 32'd0);
        check("to_late_lsu", {31'd0, a_lsu_respValid}, 32'd0);
        check("to_late_slv", {31'd0, a_slv_reqValid}, 32'd0);
        tick();
        slv_respValid = 1'b0;

        // Real response in the timeout cycle wins.
        tick();
        ifu_reqValid = 1'b1;
        #1;
        tick();
        ifu_reqValid = 1'b0;
        tick();
        tick();
        tick();
        slv_respValid = 1'b1;
        slv_rdata = 32'h0BAD_0001;
        #1;
        check("race_resp", {31'd0, a_ifu_respValid}, 32'd1);
        check("race_err", {31'd0, a_ifu_respErr}, 32'd0);
        check("race_rdata", a_ifu_rdata, 32'h0BAD_0001);
        tick();
        slv_respValid = 1'b0;

        // Reset mid-BUSY with a response arriving: outputs drop without a clock edge.
        tick();
        lsu_reqValid = 1'b1;
        lsu_addr = 32'h8000_0400;
        lsu_wen = 1'b0;
        tick();
        slv_respValid = 1'b1;
        slv_rdata = 32'h5555_AAAA;
        #1;
        check("rb_busy", {31'd0, a_slv_reqValid}, 32'd1);
        rst = 1'b0;
        #1;
        check("rb_slv_valid", {31'd0, a_slv_reqValid}, 32'd0);
        check("rb_slv_addr", a_slv_addr, 32'd0);
        check("rb_lsu_resp", {31'd0, a_lsu_respValid}, 32'd0);
        check("rb_lsu_rdata", a_lsu_rdata, 32'd0);
        check("rb_lsu_ready", {31'd0, a_lsu_reqReady}, 32'd0);
        tick();
        idle_inputs();
        #1;
        check("rb_hold_resp", {31'd0, a_lsu_respValid}, 32'd0);
        tick();
        rst = 1'b1;
        ifu_reqValid = 1'b1;
        ifu_raddr = 32'h8000_0500;
        #1;
        check("rb_ifu_ready", {31'd0, a_ifu_reqReady}, 32'd1);
        tick();
        ifu_reqValid = 1'b0;
        #1;
        check("rb_ifu_slv_valid", {31'd0, a_slv_reqValid}, 32'd1);
        check("rb_ifu_slv_addr", a_slv_addr, 32'h8000_0500);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
